// File: rtl/hy4_s2b_if.sv
// hy4_s2b_if: digit-serial input stream and parallel result bus of the stream-to-binary converter
interface hy4_s2b_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_first;
  logic         in_n2;
  logic         in_p;
  logic         in_pp;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_abort;
  modport master (output in_valid, in_first, in_n2, in_p, in_pp,
                  input out_valid, out_data, out_ovf, out_abort);
  modport slave (input in_valid, in_first, in_n2, in_p, in_pp,
                 output out_valid, out_data, out_ovf, out_abort);
endinterface

// File: rtl/hy4_s2b.sv
// hy4_s2b: collects a W-digit hybrid redundant word LSB first and emits its two's-complement value with overflow
module hy4_s2b #(
  parameter int W = 16
) (
  input logic clk,
  input logic rst,
  hy4_s2b_if.slave s
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic {IDLE, ACC} state_t;
  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [W-1:0]   r_p, r_pp, r_n, w_p_nx, w_pp_nx, w_n_nx;
  logic [W+2:0]   w_r;
  logic [W-1:0]   r_data;
  logic           r_valid, r_abort, r_ovf;
  logic           w_start, w_acc, w_take, w_done, w_abort;
  // a first-flagged digit always begins a new word; plain digits only count inside a word
  assign w_start  = s.in_valid & s.in_first;
  assign w_acc    = (r_state == ACC) & s.in_valid & ~s.in_first;
  assign w_take   = w_start | w_acc;
  assign w_cnt_nx = w_start ? CW'(1) : r_cnt + CW'(1);
  assign w_done   = w_acc & (w_cnt_nx == CW'(W));
  assign w_abort  = (r_state == ACC) & w_start;
  assign w_p_nx   = {s.in_p, r_p[W-1:1]};
  assign w_pp_nx  = {s.in_pp, r_pp[W-1:1]};
  assign w_n_nx   = {s.in_n2, r_n[W-1:1]};
  assign w_r      = {3'b000, w_p_nx} + {3'b000, w_pp_nx} - {2'b00, w_n_nx, 1'b0};
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_start ? ACC : IDLE;
    else w_next = w_done ? IDLE : ACC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_pp    <= '0;
      r_n     <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_abort <= w_abort;
      if (w_take) begin
        r_p   <= w_p_nx;
        r_pp  <= w_pp_nx;
        r_n   <= w_n_nx;
        r_cnt <= w_done ? '0 : w_cnt_nx;
      end
      if (w_done) begin
        r_data <= w_r[W-1:0];
        r_ovf  <= ~(&w_r[W+2:W-1] | ~|w_r[W+2:W-1]);
      end
    end
  end
  assign s.out_valid = r_valid;
  assign s.out_abort = r_abort;
  assign s.out_data  = r_data;
  assign s.out_ovf   = r_ovf;
endmodule

// File: tb/tb_hy4_s2b.sv
// tb_hy4_s2b: directed checks of the stream-to-binary converter at W=8
module tb_hy4_s2b;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, nv = 0, na = 0, cyc = 0, tv = 0, tv_prev = 0, n0 = 0, a0 = 0;
  always #5 clk = ~clk;
  hy4_s2b_if #(.W(W)) bus();
  hy4_s2b #(.W(W)) dut (.clk(clk), .rst(rst), .s(bus.slave));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.out_valid) begin
      nv <= nv + 1;
      tv_prev <= tv;
      tv <= cyc;
    end
    if (bus.out_abort) na <= na + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic dig(input logic f, input logic n2, input logic p, input logic pp);
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_n2 = n2;
    bus.in_p = p;
    bus.in_pp = pp;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic word(input logic [7:0] p, input logic [7:0] pp, input logic [7:0] n, input bit st);
    for (int i = 0; i < W; i++) begin
      dig(i == 0, n[i], p[i], pp[i]);
      if (st && (i == 2 || i == 5)) begin
        idle(3);
        chk("stall_quiet", {31'd0, bus.out_valid}, 32'd0);
      end
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_n2 = 1'b0;
    bus.in_p = 1'b0;
    bus.in_pp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_abort", {31'd0, bus.out_abort}, 32'd0);
    chk("rst_data", {24'd0, bus.out_data}, 32'h00);
    chk("rst_ovf", {31'd0, bus.out_ovf}, 32'd0);
    rst = 1'b0;
    word(8'h05, 8'h03, 8'h02, 1'b0);
    chk("basic_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("basic_data", {24'd0, bus.out_data}, 32'h04);
    chk("basic_ovf", {31'd0, bus.out_ovf}, 32'd0);
    idle(1);
    chk("basic_pulse", {31'd0, bus.out_valid}, 32'd0);
    chk("basic_count", nv, 1);
    chk("basic_hold", {24'd0, bus.out_data}, 32'h04);
    word(8'h00, 8'h00, 8'h01, 1'b0);
    chk("neg_data", {24'd0, bus.out_data}, 32'hFE);
    chk("neg_ovf", {31'd0, bus.out_ovf}, 32'd0);
    word(8'hFF, 8'hFF, 8'h00, 1'b0);
    chk("ovf_data", {24'd0, bus.out_data}, 32'hFE);
    chk("ovf_flag", {31'd0, bus.out_ovf}, 32'd1);
    idle(1);
    n0 = nv;
    word(8'h05, 8'h03, 8'h02, 1'b1);
    chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_data", {24'd0, bus.out_data}, 32'h04);
    chk("stall_ovf", {31'd0, bus.out_ovf}, 32'd0);
    idle(1);
    chk("stall_count", nv - n0, 1);
    n0 = nv;
    a0 = na;
    for (int i = 0; i < 4; i++) dig(i == 0, 1'b1, 1'b1, 1'b0);
    dig(1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_abort", {31'd0, bus.out_abort}, 32'd1);
    chk("restart_novalid", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 1; i < W; i++) dig(1'b0, 1'b0, i < 7, 1'b0);
    chk("restart_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("restart_data", {24'd0, bus.out_data}, 32'h7F);
    chk("restart_ovf", {31'd0, bus.out_ovf}, 32'd0);
    idle(1);
    chk("restart_abort_cnt", na - a0, 1);
    chk("restart_valid_cnt", nv - n0, 1);
    n0 = nv;
    word(8'h10, 8'h00, 8'h00, 1'b0);
    chk("b2b_valid1", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_data1", {24'd0, bus.out_data}, 32'h10);
    word(8'h00, 8'h00, 8'h08, 1'b0);
    chk("b2b_valid2", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_data2", {24'd0, bus.out_data}, 32'hF0);
    chk("b2b_ovf2", {31'd0, bus.out_ovf}, 32'd0);
    idle(1);
    chk("b2b_count", nv - n0, 2);
    chk("b2b_spacing", tv - tv_prev, W);
    n0 = nv;
    a0 = na;
    for (int i = 0; i < 5; i++) dig(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("stray_valid_cnt", nv - n0, 0);
    chk("stray_abort_cnt", na - a0, 0);
    chk("stray_hold", {24'd0, bus.out_data}, 32'hF0);
    a0 = na;
    for (int i = 0; i < 4; i++) dig(i == 0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    dig(1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_abort", {31'd0, bus.out_abort}, 32'd0);
    chk("mrst_data", {24'd0, bus.out_data}, 32'h00);
    chk("mrst_ovf", {31'd0, bus.out_ovf}, 32'd0);
    idle(1);
    chk("mrst_abort_cnt", na - a0, 0);
    word(8'h33, 8'h11, 8'h05, 1'b0);
    chk("mrst_word_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mrst_word_data", {24'd0, bus.out_data}, 32'h3A);
    chk("mrst_word_ovf", {31'd0, bus.out_ovf}, 32'd0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hy4_s2b.md
# hy4_s2b

Stream-to-binary converter for the hybrid redundant digit-serial datapath. It sits directly downstream of the hybrid serial adder/subtractor stages. It collects one W-digit word per transaction, LSB first, one digit per accepted cycle, and emits the equivalent signed two's-complement word with an overflow flag. It is the exit point from the serial redundant domain into parallel binary logic such as the FIR output register and the saturation stage.

## Interface
- W, default 16: word length in digits and width of `out_data`. Legal range is 4..32.
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  the digit on `in_n2`/`in_p`/`in_pp` is valid this cycle.
- in_first  in  1  marks digit 0 (LSB) of a word. Sampled only when `in_valid`=1.
- in_n2  in  1  negative component of the digit, weight −2^(i+1).
- in_p  in  1  positive component of the digit, weight +2^i.
- in_pp  in  1  second positive component of the digit, weight +2^i.
- out_valid  out  1  single-cycle pulse; `out_data`/`out_ovf` are valid.
- out_data  out  W  result modulo 2^W, two's complement.
- out_ovf  out  1  true result lies outside [−2^(W−1), 2^(W−1)−1].
- out_abort  out  1  single-cycle pulse; a partial word was discarded.

## Operation
- Digit i of a word has value d_i = p_i + pp_i − 2·n2_i. The word value is V = Σ d_i·2^i for i = 0..W−1.
- Three W-bit shift registers P, PP and N capture the components LSB first. An accepted digit shifts in at the MSB end, so after W digits bit i holds digit i.
- At completion, R = P + PP − (N<<1) is computed signed in W+3 bits, with P, PP and N zero-extended.
  - out_data = R[W−1:0].
  - out_ovf = 1 iff R[W+2:W−1] is not all-equal.
- The state machine has two states.
  - IDLE: wait for `in_valid`=1 with `in_first`=1. Accept that digit as digit 0, set cnt=1, go to ACC.
  - In IDLE, `in_valid`=1 with `in_first`=0 is ignored. The digit is dropped and no pulse is generated.
  - ACC: each cycle with `in_valid`=1 and `in_first`=0 accepts digit cnt and increments cnt.
  - In ACC, the digit that makes cnt reach W completes the word. The block then returns to IDLE.
  - In ACC, `in_valid`=0 is a stall. cnt and the registers hold, with no timeout.
  - In ACC, `in_valid`=1 with `in_first`=1 is a restart. It pulses `out_abort`, discards the partial word, accepts this digit as digit 0, sets cnt=1, and stays in ACC.
- cnt is ceil(log2(W+1)) bits wide. It never wraps; it is cleared when the block returns to IDLE.
- For W=1 words, `in_first` on the final digit is not supported; the legal range of W excludes this case.

## Timing
- Latency: `out_valid` pulses exactly 1 cycle after the cycle that accepted digit W−1.
  - `out_data` and `out_ovf` are registered and hold their values until the next completion.
- Back-to-back words are supported. A `in_first` digit in the cycle right after the final digit is accepted from IDLE, giving a sustained throughput of one word per W cycles.
- `out_abort` pulses 1 cycle after the restart digit is accepted.
- `out_abort` and `out_valid` never assert in the same cycle.
- Reset values: out_valid=0, out_abort=0, out_data=0, out_ovf=0, cnt=0, P=PP=N=0, state=IDLE.
- Reset mid-word: the partial word is discarded silently, with no `out_abort`. The first `in_first` digit after `rst` deasserts starts a fresh word.
- Reset takes priority over all inputs in the same cycle.

## Test plan
- **Basic conversion.** W=8; P word=0x05, PP=0x03, N=0x02, fed over 8 consecutive digits -> out_valid 1 cycle after digit 7, out_data=0x04, out_ovf=0.
- **Negative result and overflow.** W=8; only n2_0=1 -> out_data=0xFE, out_ovf=0. Then P=0xFF, PP=0xFF, N=0 -> R=510, out_data=0xFE, out_ovf=1.
- **Stalls.** Same stimulus as the basic case with `in_valid` low for 3 cycles after digits 2 and 5 -> identical result, out_valid 1 cycle after the last accepted digit.
- **Restart.** 4 digits, then `in_first` with a new full word of P=0x7F -> out_abort pulse, followed later by out_valid, out_data=0x7F, out_ovf=0.
- **Back-to-back and stray digits.** Two words with no gap (results 0x10 then 0xF0) -> two out_valid pulses W cycles apart. Digits with `in_first`=0 sent while idle -> no output.
- **Reset mid-word.** `rst` asserted after digit 3 -> all outputs 0 and no out_abort. A full word sent afterwards converts correctly.
